iq_decim_avg: RTL and testbench



---
 rtl/iq_decim_avg.sv | 115 +++++++++++
 tb/tb_iq_decim_avg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/iq_decim_avg.sv
// iq_decim_avg: integrate-and-dump decimator for the 12-bit I/Q RX stream.
// Averages each window of 2^LOG2_DECIM samples per channel and emits one
// round-half-up result per window, with valid/ready on both sides.
module iq_decim_avg #(
    parameter int DATA_WIDTH = 12,
    parameter int LOG2_DECIM = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [DATA_WIDTH-1:0] in_data_q,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data_i,
    output logic [DATA_WIDTH-1:0] out_data_q,
    input  logic                  out_ready
);

    localparam int N  = 1 << LOG2_DECIM;
    localparam int AW = DATA_WIDTH + LOG2_DECIM;
    localparam int CW = (LOG2_DECIM == 0) ? 1 : LOG2_DECIM;
    // Half an LSB of the output; N>>1 is 0 for the pass-through case.
    localparam int RND = N >> 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(N - 1);
    localparam logic signed [AW-1:0] RND_V    = AW'(RND);

    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_i_q, out_i_d;
    logic [DATA_WIDTH-1:0]  out_q_q, out_q_d;
    logic signed [AW-1:0]   acc_i_q, acc_i_d;
    logic signed [AW-1:0]   acc_q_q, acc_q_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   accept;
    logic signed [AW-1:0]   acc_base_i, acc_base_q;
    logic [CW-1:0]          cnt_base;
    logic signed [AW-1:0]   in_ext_i, in_ext_q;
    logic signed [AW-1:0]   sum_i, sum_q;
    logic signed [AW-1:0]   rnd_i, rnd_q;

    // Stall input only when the window about to close has nowhere to go.
    assign in_ready = !rst && !(out_valid_q && !out_ready && (cnt_q == CNT_LAST));
    assign accept   = in_valid && in_ready;

    assign out_valid  = out_valid_q;
    assign out_data_i = out_i_q;
    assign out_data_q = out_q_q;

    // Next-state: flush restarts the window, accepted samples accumulate or dump.
    always_comb begin
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;

        // Flush takes effect before the sample of the same cycle is added,
        // so that sample becomes the first of the new window.
        acc_base_i = flush ? '0 : acc_i_q;
        acc_base_q = flush ? '0 : acc_q_q;
        cnt_base   = flush ? '0 : cnt_q;

        acc_i_d = acc_base_i;
        acc_q_d = acc_base_q;
        cnt_d   = cnt_base;

        in_ext_i = AW'(signed'(in_data_i));
        in_ext_q = AW'(signed'(in_data_q));
        sum_i    = acc_base_i + in_ext_i;
        sum_q    = acc_base_q + in_ext_q;
        // Cannot overflow AW bits: |N full-scale samples| + N/2 stays in range.
        rnd_i    = sum_i + RND_V;
        rnd_q    = sum_q + RND_V;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (cnt_base == CNT_LAST) begin
                out_valid_d = 1'b1;
                out_i_d     = DATA_WIDTH'(rnd_i >>> LOG2_DECIM);
                out_q_d     = DATA_WIDTH'(rnd_q >>> LOG2_DECIM);
                acc_i_d     = '0;
                acc_q_d     = '0;
                cnt_d       = '0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                cnt_d   = cnt_base + CW'(1);
            end
        end
    end

    // State registers with synchronous reset; reset also drops a pending output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_iq_decim_avg.sv
// Directed vector table for the N=8 decimator plus a randomized
// scoreboard run on a pass-through (LOG2_DECIM=0) instance.
module tb_iq_decim_avg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [11:0] in_data_i, in_data_q;
    logic        in_ready, out_valid;
    logic [11:0] out_data_i, out_data_q;

    logic        p_flush, p_valid, p_ordy;
    logic [11:0] p_i, p_q;
    logic        p_rdy, p_ov;
    logic [11:0] p_oi, p_oq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iq_decim_avg #(.DATA_WIDTH(12), .LOG2_DECIM(3)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_data_i(in_data_i), .in_data_q(in_data_q), .in_ready(in_ready),
        .out_valid(out_valid), .out_data_i(out_data_i), .out_data_q(out_data_q),
        .out_ready(out_ready)
    );

    iq_decim_avg #(.DATA_WIDTH(12), .LOG2_DECIM(0)) u_pass (
        .clk(clk), .rst(rst), .flush(p_flush), .in_valid(p_valid),
        .in_data_i(p_i), .in_data_q(p_q), .in_ready(p_rdy),
        .out_valid(p_ov), .out_data_i(p_oi), .out_data_q(p_oq),
        .out_ready(p_ordy)
    );

    typedef struct {
        logic        r, f, v;
        logic [11:0] di, dq;
        logic        o;
        logic        erdy, eov, chkd;
        logic [11:0] ei, eq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit f, bit v, int di, int dq, bit o,
                                bit erdy, bit eov, bit chkd, int ei, int eq);
        vec_t x;
        x.r = r; x.f = f; x.v = v; x.di = 12'(di); x.dq = 12'(dq); x.o = o;
        x.erdy = erdy; x.eov = eov; x.chkd = chkd; x.ei = 12'(ei); x.eq = 12'(eq);
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    typedef struct { logic [11:0] i, q; } pair_t;
    pair_t sb[$];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data_i = '0; in_data_q = '0;
        p_flush = 1'b0; p_valid = 1'b0; p_ordy = 1'b1; p_i = '0; p_q = '0;

        // reset
        add(1,0,0,0,0,1, 0,0,1,0,0);
        add(1,0,0,0,0,1, 0,0,1,0,0);
        // steady DC: two windows of I=100, Q=-100
        for (int k = 1; k <= 16; k++)
            add(0,0,1,100,-100,1, 1,(k%8)==0,(k%8)==0,100,-100);
        add(0,0,0,0,0,1, 1,0,0,0,0);
        // rounding: sum 4 -> 1, sum -4 -> 0
        for (int k = 1; k <= 8; k++)
            add(0,0,1,(k==8)?4:0,(k==8)?-4:0,1, 1,k==8,k==8,1,0);
        // full scale
        for (int k = 1; k <= 8; k++)
            add(0,0,1,2047,-2048,1, 1,k==8,k==8,2047,-2048);
        // sum 4 -> 1, sum -5 -> -1
        for (int k = 1; k <= 8; k++)
            add(0,0,1,(k<=4)?1:0,(k==1)?-5:0,1, 1,k==8,k==8,1,-1);
        add(0,0,0,0,0,1, 1,0,0,0,0);
        // backpressure: window 10 then window 16..23 (avg 19.5 -> 20, -19.5 -> -19)
        for (int k = 1; k <= 8; k++)
            add(0,0,1,10,-10,1, 1,k==8,k==8,10,-10);
        for (int k = 9; k <= 15; k++)
            add(0,0,1,k+7,-(k+7),0, 1,1,1,10,-10);
        add(0,0,1,23,-23,0, 0,1,1,10,-10);
        add(0,0,1,23,-23,0, 0,1,1,10,-10);
        add(0,0,1,23,-23,1, 1,1,1,20,-19);
        add(0,0,0,0,0,1, 1,0,0,0,0);
        // flush at cnt=5 with pending output 30
        for (int k = 1; k <= 8; k++)
            add(0,0,1,30,-30,0, 1,k==8,k==8,30,-30);
        for (int k = 1; k <= 5; k++)
            add(0,0,1,50,50,0, 1,1,1,30,-30);
        add(0,1,1,8,8,0, 1,1,1,30,-30);
        for (int k = 1; k <= 7; k++)
            add(0,0,1,8,8,1, 1,k==7,k==7,8,8);
        add(0,0,0,0,0,1, 1,0,0,0,0);
        // reset mid-window with pending output
        for (int k = 1; k <= 8; k++)
            add(0,0,1,40,40,0, 1,k==8,k==8,40,40);
        for (int k = 1; k <= 4; k++)
            add(0,0,1,99,99,0, 1,1,1,40,40);
        add(1,0,1,99,99,0, 0,0,1,0,0);
        for (int k = 1; k <= 8; k++)
            add(0,0,1,20,20,1, 1,k==8,k==8,20,20);
        add(0,0,0,0,0,1, 1,0,0,0,0);

        foreach (vecs[n]) begin
            rst = vecs[n].r; flush = vecs[n].f; in_valid = vecs[n].v;
            in_data_i = vecs[n].di; in_data_q = vecs[n].dq; out_ready = vecs[n].o;
            #1;
            chk("in_ready", n, int'(in_ready), int'(vecs[n].erdy));
            @(posedge clk); #1;
            chk("out_valid", n, int'(out_valid), int'(vecs[n].eov));
            if (vecs[n].chkd) begin
                chk("out_data_i", n, int'(out_data_i), int'(vecs[n].ei));
                chk("out_data_q", n, int'(out_data_q), int'(vecs[n].eq));
            end
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // pass-through: random data and backpressure against a scoreboard
        for (int c = 0; c < 300; c++) begin
            logic acc, prev_ov;
            pair_t s;
            p_valid = ($urandom_range(0, 3) != 0);
            p_i     = 12'($urandom);
            p_q     = 12'($urandom);
            p_ordy  = ($urandom_range(0, 2) != 0);
            #1;
            chk("p_in_ready", c, int'(p_rdy), int'(!(p_ov && !p_ordy)));
            if (p_ov && p_ordy) begin
                if (sb.size() == 0) begin
                    chk("p_unexpected_out", c, 1, 0);
                end else begin
                    s = sb.pop_front();
                    chk("p_data_i", c, int'(p_oi), int'(s.i));
                    chk("p_data_q", c, int'(p_oq), int'(s.q));
                end
            end
            acc = p_valid && p_rdy;
            if (acc) begin
                s.i = p_i; s.q = p_q;
                sb.push_back(s);
            end
            prev_ov = p_ov;
            @(posedge clk); #1;
            chk("p_out_valid", c, int'(p_ov), int'(acc || (prev_ov && !p_ordy)));
        end
        p_valid = 1'b0; p_ordy = 1'b1;
        #1;
        if (p_ov) begin
            pair_t s;
            if (sb.size() == 0) begin
                chk("p_unexpected_out", 999, 1, 0);
            end else begin
                s = sb.pop_front();
                chk("p_drain_i", 999, int'(p_oi), int'(s.i));
                chk("p_drain_q", 999, int'(p_oq), int'(s.q));
            end
        end
        @(posedge clk); #1;
        chk("p_drained_valid", 0, int'(p_ov), 0);
        chk("p_leftover", 0, sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
